// File: rtl/sequence_generator.sv
// sequence_generator: serial bit-pattern generator with length clamp, repetitions, inter-repetition gap and abort
module sequence_generator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pattern,
    input  logic [3:0]       in_len,
    input  logic [3:0]       in_reps,
    input  logic             abort,
    output logic             data,
    output logic             data_valid,
    output logic [1:0]       state_out,
    output logic             done
);
    typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, SHIFT = 2'b10, GAP = 2'b11} state_t;
    localparam logic [3:0] W4 = 4'(WIDTH);
    state_t           state;
    logic [WIDTH-1:0] pat;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] aligned;
    logic [3:0]       len;
    logic [3:0]       clen;
    logic [3:0]       bits_left;
    logic [3:0]       reps_left;
    assign in_ready  = state == IDLE;
    assign state_out = state;
    // Clamp the requested length and MSB-justify the pattern so the shifter always taps the top bit
    always_comb begin
        clen    = (in_len == 4'd0 || in_len > W4) ? W4 : in_len;
        aligned = in_pattern << (W4 - clen);
    end
    // Single FSM with registered data/data_valid/done aligned to the state they belong to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pat        <= '0;
            sreg       <= '0;
            len        <= '0;
            bits_left  <= '0;
            reps_left  <= '0;
            data       <= 1'b0;
            data_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            data       <= 1'b0;
            data_valid <= 1'b0;
            done       <= 1'b0;
            if (state != IDLE && abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (in_valid) begin
                        pat       <= aligned;
                        len       <= clen;
                        reps_left <= (in_reps == 4'd0) ? 4'd1 : in_reps;
                        state     <= LOAD;
                    end
                    LOAD, GAP: begin
                        state      <= SHIFT;
                        data       <= pat[WIDTH-1];
                        data_valid <= 1'b1;
                        sreg       <= pat << 1;
                        bits_left  <= len - 4'd1;
                    end
                    SHIFT: if (bits_left != 4'd0) begin
                        data       <= sreg[WIDTH-1];
                        data_valid <= 1'b1;
                        sreg       <= sreg << 1;
                        bits_left  <= bits_left - 4'd1;
                    end else if (reps_left == 4'd1) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        state     <= GAP;
                        reps_left <= reps_left - 4'd1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sequence_generator.sv
// tb_sequence_generator: randomized self-checking bench against a per-transfer expected-trace model
module tb_sequence_generator;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] in_pattern = 8'h00;
    logic [3:0] in_len = 4'd0;
    logic [3:0] in_reps = 4'd0;
    logic       in_ready;
    logic       data;
    logic       data_valid;
    logic       done;
    logic [1:0] state_out;
    logic [5:0] obs;
    logic [5:0] q[$];
    int         vectors = 0;
    int         miscompares = 0;
    localparam logic [5:0] IDLE_V = 6'b000001;
    localparam logic [5:0] DONE_V = 6'b000011;

    sequence_generator #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pattern(in_pattern), .in_len(in_len), .in_reps(in_reps), .abort(abort),
        .data(data), .data_valid(data_valid), .state_out(state_out), .done(done)
    );

    always #5 clk = ~clk;
    assign obs = {state_out, data, data_valid, done, in_ready};

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got st=%b d=%b dv=%b done=%b rdy=%b, expected st=%b d=%b dv=%b done=%b rdy=%b",
                     tag, got[5:4], got[3], got[2], got[1], got[0], exp[5:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            check("idle", obs, IDLE_V);
        end
    endtask

    // Present one request now; expected trace is the LOAD cycle, each repetition's bits MSB-first
    // separated by one gap cycle, then the done cycle. ab/rs index the trace cycle carrying abort/reset.
    task automatic issue(input int p, input int l, input int r, input int ab, input int rs,
                         input bit busy, input string tag);
        int len;
        int reps;
        int idx;
        len  = (l == 0 || l > 8) ? 8 : l;
        reps = (r == 0) ? 1 : r;
        q.delete();
        q.push_back(6'b010000);
        for (int k = 0; k < reps; k++) begin
            for (int i = len - 1; i >= 0; i--) q.push_back({2'b10, 1'(p >> i), 3'b100});
            if (k < reps - 1) q.push_back(6'b110000);
        end
        q.push_back(DONE_V);
        if (ab == -2) ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, q.size() - 2)) : -1;
        in_valid   = 1'b1;
        in_pattern = 8'(p);
        in_len     = 4'(l);
        in_reps    = 4'(r);
        abort      = 1'($urandom_range(0, 1));
        idx = 0;
        while (q.size() > 0) begin
            @(negedge clk);
            rst_n = 1'b1;
            check(tag, obs, q.pop_front());
            in_valid   = busy && q.size() > 0;
            in_pattern = 8'hFF;
            in_len     = 4'($urandom_range(0, 15));
            in_reps    = 4'($urandom_range(0, 15));
            abort      = (idx == ab);
            if (idx == ab || idx == rs) begin
                q.delete();
                q.push_back(IDLE_V);
            end
            if (idx == rs) begin
                #1 rst_n = 1'b0;
                #1 check({tag, "/async_rst"}, obs, IDLE_V);
            end
            idx++;
        end
        in_valid = 1'b0;
        abort    = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 check("reset", obs, IDLE_V);
        @(negedge clk);
        check("reset_hold", obs, IDLE_V);
        rst_n = 1'b1;
        issue(8'h0D, 4, 1, -1, -1, 1'b0, "basic");
        idle(1);
        issue(8'h0D, 4, 2, -1, -1, 1'b0, "reps");
        idle(1);
        issue(8'hA5, 0, 0, -1, -1, 1'b0, "clamp0");
        issue(8'h03, 2, 1, -1, -1, 1'b0, "b2b");
        idle(1);
        issue(8'h0D, 4, 1, 2, -1, 1'b0, "abort");
        idle(2);
        issue(8'h0D, 4, 1, -1, -1, 1'b1, "busy");
        idle(1);
        issue(8'h0D, 4, 3, -1, 3, 1'b1, "rst_mid");
        idle(3);
        issue(8'h81, 1, 1, -1, -1, 1'b0, "len1");
        issue(8'h5A, 9, 1, -1, -1, 1'b0, "len9");
        issue(8'hC3, 15, 2, -1, -1, 1'b0, "len15");
        idle(1);
        repeat (60) begin
            issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), int'($urandom_range(0, 4)),
                  -2, -1, 1'($urandom_range(0, 1)), "rand");
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
        end
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
